pc_sequencer: RTL

- Next-PC and run-control stage directly upstream of the PC register in the single-cycle RISC-V CPU.
- Computes the next PC from the current PC and the decoded control-flow signals, and drives the PC register's clock-enable.
- Runs a run/step/halt state machine driven by the board Go button.
- Keeps the statistics counters: total cycles, unconditional jumps, conditional branches taken.

---
 rtl/pc_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Next-PC selection, PC clock-enable and run/step/halt control for the single-cycle RISC-V core.
// Also keeps the executed-instruction, jump and taken-branch statistics counters.
`timescale 1ns / 1ps
module pc_sequencer #(
    parameter int unsigned     XLen        = 32,
    parameter int unsigned     CntBits     = 16,
    parameter logic [XLen-1:0] ResetVector = '0
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Go,
    input  logic               StepMode,
    input  logic [XLen-1:0]    Pc,
    input  logic [XLen-1:0]    Imm,
    input  logic [XLen-1:0]    Rs1,
    input  logic               Jal,
    input  logic               Jalr,
    input  logic               Branch,
    input  logic               BrTaken,
    input  logic               HaltInstr,
    output logic [XLen-1:0]    NextPc,
    output logic               PcEnable,
    output logic               Halted,
    output logic               Running,
    output logic [CntBits-1:0] CycleCnt,
    output logic [CntBits-1:0] JumpCnt,
    output logic [CntBits-1:0] BranchCnt
);

    typedef enum logic [1:0] {StIdle, StRun, StStepWait, StHalted} state_t;

    localparam logic [CntBits-1:0] CntOne = CntBits'(1);

    state_t          state;
    state_t          state_next;
    logic            go_d;
    logic            go_arm;
    logic            go_pulse;
    logic            exec;
    logic            resume;
    logic            is_jump;
    logic            is_br;
    logic [XLen-1:0] pc_plus4;
    logic [XLen-1:0] jalr_target;

    // go_arm stays low until Go is seen released, so a press held through reset never fires.
    assign go_pulse    = Go & ~go_d & go_arm;
    assign exec        = (state == StRun) | ((state == StStepWait) & go_pulse);
    assign resume      = (state == StHalted) & go_pulse;
    assign is_jump     = Jal | Jalr;
    assign is_br       = Branch & BrTaken & ~is_jump;
    assign pc_plus4    = Pc + XLen'(4);
    assign jalr_target = (Rs1 + Imm) & ~XLen'(1);

    always_comb begin
        NextPc = pc_plus4;
        if (state == StIdle) begin
            NextPc = ResetVector;
        end else if (resume) begin
            NextPc = pc_plus4;
        end else if (Jalr) begin
            NextPc = jalr_target;
        end else if (Jal || (Branch && BrTaken)) begin
            NextPc = Pc + Imm;
        end
    end

    always_comb begin
        PcEnable   = 1'b0;
        state_next = state;
        unique case (state)
            StIdle: begin
                if (go_pulse) state_next = StepMode ? StStepWait : StRun;
            end
            StRun: begin
                PcEnable = ~HaltInstr;
                if (HaltInstr)     state_next = StHalted;
                else if (StepMode) state_next = StStepWait;
            end
            StStepWait: begin
                PcEnable = exec & ~HaltInstr;
                if (exec && HaltInstr) state_next = StHalted;
                else if (!StepMode)    state_next = StRun;
            end
            StHalted: begin
                // Resume steps past the halt instruction without counting it again.
                PcEnable = go_pulse;
                if (go_pulse) state_next = StepMode ? StStepWait : StRun;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= StIdle;
            go_d      <= 1'b0;
            go_arm    <= 1'b0;
            Halted    <= 1'b0;
            Running   <= 1'b0;
            CycleCnt  <= '0;
            JumpCnt   <= '0;
            BranchCnt <= '0;
        end else begin
            go_d    <= Go;
            if (!Go) go_arm <= 1'b1;
            state   <= state_next;
            Halted  <= (state_next == StHalted);
            Running <= (state_next == StRun) || (state_next == StStepWait);
            if (exec) begin
                CycleCnt <= CycleCnt + CntOne;
                if (is_jump && !HaltInstr) JumpCnt   <= JumpCnt + CntOne;
                if (is_br && !HaltInstr)   BranchCnt <= BranchCnt + CntOne;
            end
        end
    end

endmodule
